btn_clasificador: RTL and testbench

- Stage directly downstream of the button debouncer. Consumes its clean level output `boton_out`, wired here to `boton_in`.
- Classifies each press as short or long and emits single-cycle event pulses for the control FSM (menu navigation, confirm/cancel).
- One instance per physical button.

---
 rtl/btn_clasificador.sv | 137 +++++++++++++
 tb/tb_btn_clasificador.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/btn_clasificador.sv
// Press classifier behind the button debouncer: emits one-cycle start/short/long pulses
// plus a "press tracked" level. Optional auto-repeat of the long pulse under `BTN_REPEAT_EN.
module btn_clasificador #(
  parameter int COUNT_LONG = 150000000,
  parameter int COUNT_REP  = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic boton_in,
  output logic pulso_flanco,
  output logic pulso_corto,
  output logic pulso_largo,
  output logic presionado
);

  localparam int CW = $clog2(COUNT_LONG + 1);
  localparam logic [CW-1:0] LONG_C = CW'(COUNT_LONG);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic            boton_prev_r;
  logic            flanco_s, corto_s, largo_s, pres_s;

`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(COUNT_REP + 1);
  localparam logic [RW-1:0] REP_C    = RW'(COUNT_REP);
  localparam logic [RW-1:0] REP_ZERO = RW'(0);
  logic [RW-1:0]   rep_r, rep_s, rep_inc_s;
  assign rep_inc_s = rep_r + RW'(1);
`endif

  assign cnt_inc_s = cnt_r + ONE_C;

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    flanco_s = 1'b0;
    corto_s  = 1'b0;
    largo_s  = 1'b0;
    pres_s   = presionado;
`ifdef BTN_REPEAT_EN
    rep_s    = rep_r;
`endif
    case (state_r)
      IDLE: begin
        if (boton_in && !boton_prev_r) begin
          state_s  = PRESSED;
          cnt_s    = ONE_C;
          flanco_s = 1'b1;
          pres_s   = 1'b1;
        end else begin
          cnt_s  = ZERO_C;
          pres_s = 1'b0;
        end
      end
      PRESSED: begin
        if (boton_in) begin
          if (cnt_inc_s == LONG_C) begin
            state_s = LONG_HELD;
            cnt_s   = LONG_C;
            largo_s = 1'b1;
`ifdef BTN_REPEAT_EN
            rep_s   = REP_ZERO;
`endif
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          state_s = IDLE;
          cnt_s   = ZERO_C;
          corto_s = 1'b1;
          pres_s  = 1'b0;
        end
      end
      LONG_HELD: begin
        if (!boton_in) begin
          state_s = IDLE;
          cnt_s   = ZERO_C;
          pres_s  = 1'b0;
        end else begin
          // Counter stays saturated at the long threshold while held
          cnt_s = LONG_C;
`ifdef BTN_REPEAT_EN
          if (rep_inc_s == REP_C) begin
            rep_s   = REP_ZERO;
            largo_s = 1'b1;
          end else begin
            rep_s = rep_inc_s;
          end
`endif
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_C;
        pres_s  = 1'b0;
      end
    endcase
  end

  // State, counter, edge-history and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO_C;
      boton_prev_r <= 1'b1;
      pulso_flanco <= 1'b0;
      pulso_corto  <= 1'b0;
      pulso_largo  <= 1'b0;
      presionado   <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep_r        <= REP_ZERO;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      boton_prev_r <= boton_in;
      pulso_flanco <= flanco_s;
      pulso_corto  <= corto_s;
      pulso_largo  <= largo_s;
      presionado   <= pres_s;
`ifdef BTN_REPEAT_EN
      rep_r        <= rep_s;
`endif
    end
  end

endmodule

// File: tb/tb_btn_clasificador.sv
// Self-checking bench for btn_clasificador with COUNT_LONG=10, COUNT_REP=4.
// Expected outputs {flanco, corto, largo, presionado} are queued per driven sample and checked one cycle later.
module tb_btn_clasificador;

  logic clk;
  logic rst;
  logic boton_in;
  logic pulso_flanco, pulso_corto, pulso_largo, presionado;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    logic       r;
    logic       b;
    logic [3:0] e;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  btn_clasificador #(.COUNT_LONG(10), .COUNT_REP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .boton_in     (boton_in),
    .pulso_flanco (pulso_flanco),
    .pulso_corto  (pulso_corto),
    .pulso_largo  (pulso_largo),
    .presionado   (presionado)
  );

  always #10 clk = ~clk;

  task automatic check_pending();
    logic [3:0] e;
    logic [3:0] act;
    string n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {pulso_flanco, pulso_corto, pulso_largo, presionado};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s got={f,c,l,p}=%b expected=%b at %0t", n, act, e, $time);
      end
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [3:0] e, input string nm);
    @(negedge clk);
    check_pending();
    rst      = r;
    boton_in = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  function automatic void add(input logic r, input logic b, input logic [3:0] e, input string nm);
    vec_t v;
    v.r = r; v.b = b; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  // Press of n high samples followed by release; threshold pulses derived from the counts
  task automatic hold_press(input int n, input string nm);
    logic [3:0] e;
    logic       is_long;
    is_long = (n >= 10);
    for (int i = 1; i <= n; i++) begin
      e = 4'b0001;
      if (i == 1) e = 4'b1001;
      if (i == 10) e = 4'b0011;
`ifdef BTN_REPEAT_EN
      if (i > 10 && ((i - 10) % 4) == 0) e = 4'b0011;
`endif
      drive(1'b0, 1'b1, e, nm);
    end
    drive(1'b0, 1'b0, is_long ? 4'b0000 : 4'b0100, {nm, "_release"});
    drive(1'b0, 1'b0, 4'b0000, {nm, "_idle"});
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    boton_in = 1'b0;

    // Reset and 3-sample short press
    add(1'b1, 1'b0, 4'b0000, "reset0");
    add(1'b1, 1'b0, 4'b0000, "reset1");
    add(1'b0, 1'b0, 4'b0000, "idle_after_reset");
    add(1'b0, 1'b1, 4'b1001, "short3_flanco");
    add(1'b0, 1'b1, 4'b0001, "short3_hold2");
    add(1'b0, 1'b1, 4'b0001, "short3_hold3");
    add(1'b0, 1'b0, 4'b0100, "short3_corto");
    add(1'b0, 1'b0, 4'b0000, "short3_idle");
    // Two 2-sample presses separated by a single low sample
    add(1'b0, 1'b1, 4'b1001, "dbl_flanco1");
    add(1'b0, 1'b1, 4'b0001, "dbl_hold1");
    add(1'b0, 1'b0, 4'b0100, "dbl_corto1");
    add(1'b0, 1'b1, 4'b1001, "dbl_flanco2");
    add(1'b0, 1'b1, 4'b0001, "dbl_hold2");
    add(1'b0, 1'b0, 4'b0100, "dbl_corto2");
    add(1'b0, 1'b0, 4'b0000, "dbl_idle");

    foreach (tbl[i]) drive(tbl[i].r, tbl[i].b, tbl[i].e, tbl[i].nm);

    // Threshold boundary: 9 samples is short, 10 is long
    hold_press(9, "hold9");
    hold_press(10, "hold10");

    // Button held through reset is ignored until released and pressed again
    drive(1'b1, 1'b1, 4'b0000, "rsthold_rst0");
    drive(1'b1, 1'b1, 4'b0000, "rsthold_rst1");
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 4'b0000, "rsthold_ignored");
    drive(1'b0, 1'b0, 4'b0000, "rsthold_low");
    drive(1'b0, 1'b1, 4'b1001, "rsthold_flanco");
    drive(1'b0, 1'b1, 4'b0001, "rsthold_hold2");
    drive(1'b0, 1'b1, 4'b0001, "rsthold_hold3");
    drive(1'b0, 1'b0, 4'b0100, "rsthold_corto");
    drive(1'b0, 1'b0, 4'b0000, "rsthold_idle");

    // Reset at the 5th high sample aborts the press silently
    drive(1'b0, 1'b1, 4'b1001, "abort_flanco");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'b0001, "abort_hold");
    drive(1'b1, 1'b1, 4'b0000, "abort_rst");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'b0000, "abort_after_rst");
    drive(1'b0, 1'b0, 4'b0000, "abort_release");
    drive(1'b0, 1'b0, 4'b0000, "abort_idle");

    // Long hold: one pulse at 10, or repeats at 14 and 18 with auto-repeat
    hold_press(18, "hold18");

    @(negedge clk);
    check_pending();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
